// File: rtl/branch_predictor_table.sv
// ============================================================================
// Module      : branch_predictor_table
// Description : Table of saturating branch-direction counters with a
//               registered prediction port, an execute update port and a
//               self-walking table clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_table #(
    parameter int INDEX_BITS = 5,
    parameter int CTR_BITS   = 2,
    parameter int INIT_STATE = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic [INDEX_BITS-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_addr,
    input  logic                  taken,
    input  logic                  clear,
    output logic                  prediction,
    output logic                  pred_strong,
    output logic                  busy
);

    localparam int                    c_ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]   c_CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]   c_CTR_MIN  = '0;
    localparam logic [CTR_BITS-1:0]   c_CTR_ONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0]   c_INIT     = CTR_BITS'(INIT_STATE);
    localparam logic [INDEX_BITS-1:0] c_LAST_IDX = '1;
    localparam logic [INDEX_BITS-1:0] c_IDX_ONE  = INDEX_BITS'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [INDEX_BITS-1:0] r_clr_idx;
    logic [INDEX_BITS-1:0] w_clr_idx_next;
    logic                  r_prediction;
    logic                  r_pred_strong;

    logic [CTR_BITS-1:0]   w_ctr [c_ENTRIES];
    logic                  w_busy;
    logic                  w_upd;
    logic [CTR_BITS-1:0]   w_upd_old;
    logic [CTR_BITS-1:0]   w_upd_new;
    logic [CTR_BITS-1:0]   w_rd_val;

    assign w_busy    = (r_state == c_ST_CLEAR);
    assign w_upd     = en && wr_en && !w_busy;
    assign w_upd_old = w_ctr[wr_addr];

    always_comb begin
        w_upd_new = w_upd_old;
        if (taken) begin
            if (w_upd_old != c_CTR_MAX) begin
                w_upd_new = w_upd_old + c_CTR_ONE;
            end
        end else if (w_upd_old != c_CTR_MIN) begin
            w_upd_new = w_upd_old - c_CTR_ONE;
        end
    end

    // Same-index update forwards its new value so fetch never sees stale state.
    assign w_rd_val = (w_upd && (rd_addr == wr_addr)) ? w_upd_new : w_ctr[rd_addr];

    // ------------------------------------------------------------------------
    // Counter storage: the clear walk and execute updates are mutually
    // exclusive because updates are only accepted while not busy.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_ENTRIES; gi++) begin : g_entry
        logic [CTR_BITS-1:0] r_val;
        logic                w_walk_hit;
        logic                w_upd_hit;

        assign w_walk_hit = w_busy && (r_clr_idx == INDEX_BITS'(gi));
        assign w_upd_hit  = w_upd && (wr_addr == INDEX_BITS'(gi));

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                r_val <= c_INIT;
            end else if (w_walk_hit) begin
                r_val <= c_INIT;
            end else if (w_upd_hit) begin
                r_val <= w_upd_new;
            end
        end

        assign w_ctr[gi] = r_val;
    end

    // ------------------------------------------------------------------------
    // Clear walk state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= c_ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (clear) begin
                    w_state_next   = c_ST_CLEAR;
                    w_clr_idx_next = '0;
                end
            end
            c_ST_CLEAR: begin
                // A repeated clear is ignored; the walk always finishes once.
                w_clr_idx_next = r_clr_idx + c_IDX_ONE;
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next   = c_ST_IDLE;
                w_clr_idx_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered prediction port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_prediction  <= 1'b0;
            r_pred_strong <= 1'b0;
        end else if (w_busy) begin
            r_prediction  <= 1'b0;
            r_pred_strong <= 1'b0;
        end else if (en) begin
            r_prediction  <= w_rd_val[CTR_BITS-1];
            r_pred_strong <= (w_rd_val == c_CTR_MAX) || (w_rd_val == c_CTR_MIN);
        end
    end

    assign prediction  = r_prediction;
    assign pred_strong = r_pred_strong;
    assign busy        = r_state[0];

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
// ============================================================================
// Module      : tb_branch_predictor_table
// Description : Scoreboard bench for branch_predictor_table with directed
//               vectors and hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_table;

    // Expected {prediction, pred_strong, busy}
    localparam logic [2:0] c_N  = 3'b000;
    localparam logic [2:0] c_SN = 3'b010;
    localparam logic [2:0] c_WT = 3'b100;
    localparam logic [2:0] c_ST = 3'b110;
    localparam logic [2:0] c_B  = 3'b001;
    localparam logic [2:0] c_CL = 3'b111;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       en;
    logic [4:0] rd_addr;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       taken;
    logic       clear;
    logic       prediction;
    logic       pred_strong;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         vec_id = 0;
    logic       chk    = 1'b0;
    logic       chk_d  = 1'b0;
    logic [2:0] exp_q [$];
    int         id_q  [$];

    always #5 clk = ~clk;

    branch_predictor_table #(
        .INDEX_BITS (5),
        .CTR_BITS   (2),
        .INIT_STATE (1)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .en          (en),
        .rd_addr     (rd_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .taken       (taken),
        .clear       (clear),
        .prediction  (prediction),
        .pred_strong (pred_strong),
        .busy        (busy)
    );

    always @(posedge clk) chk_d <= chk;

    // Monitor: outputs after each checked edge are compared at the next negedge.
    always @(negedge clk) begin
        if (chk_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow got %b want <queued entry>",
                         {prediction, pred_strong, busy});
            end else begin
                logic [2:0] w_exp;
                int         w_id;
                w_exp = exp_q.pop_front();
                w_id  = id_q.pop_front();
                if ({prediction, pred_strong, busy} !== w_exp) begin
                    errors++;
                    $display("FAIL vec%0d pred/strong/busy got %b want %b",
                             w_id, {prediction, pred_strong, busy}, w_exp);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pred/strong/busy got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [4:0] ra, input logic we,
                         input logic [4:0] wa, input logic tk, input logic cl,
                         input logic c, input logic [2:0] exp);
        en      = e;
        rd_addr = ra;
        wr_en   = we;
        wr_addr = wa;
        taken   = tk;
        clear   = cl;
        chk     = c;
        if (c) begin
            exp_q.push_back(exp);
            id_q.push_back(vec_id);
        end
        vec_id++;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    initial begin
        arst_n  = 1'b0;
        en      = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        taken   = 1'b0;
        clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_out", {prediction, pred_strong, busy}, c_N);
        arst_n = 1'b1;

        // All entries start weakly not-taken
        for (int i = 0; i < 32; i++) drive(1, 5'(i), 0, 0, 0, 0, 1, c_N);

        // Saturate index 7 upward (reads of 7 use the bypass)
        drive(1, 7, 1, 7, 1, 0, 1, c_WT);
        drive(1, 7, 1, 7, 1, 0, 1, c_ST);
        drive(1, 8, 1, 7, 1, 0, 1, c_N);
        drive(1, 7, 0, 0, 0, 0, 1, c_ST);
        drive(1, 7, 1, 7, 1, 0, 1, c_ST);

        // Walk index 7 back down to 0 and hold there
        drive(1, 6, 1, 7, 0, 0, 1, c_N);
        drive(1, 7, 0, 0, 0, 0, 1, c_WT);
        drive(1, 6, 1, 7, 0, 0, 1, c_N);
        drive(1, 7, 0, 0, 0, 0, 1, c_N);
        drive(1, 6, 1, 7, 0, 0, 1, c_N);
        drive(1, 7, 0, 0, 0, 0, 1, c_SN);
        drive(1, 7, 1, 7, 0, 0, 1, c_SN);

        // Bypass on same index, plain read on neighbour
        drive(1, 4, 1, 4, 1, 0, 1, c_WT);
        drive(1, 5, 1, 4, 1, 0, 1, c_N);
        drive(1, 4, 0, 0, 0, 0, 1, c_ST);

        // en=0: outputs hold and updates are dropped
        drive(0, 0, 1, 4, 0, 0, 1, c_ST);
        drive(0, 0, 1, 4, 0, 0, 1, c_ST);
        drive(1, 4, 0, 0, 0, 0, 1, c_ST);

        // Clear walk with dropped updates and a redundant clear pulse
        drive(1, 0, 1, 10, 1, 0, 0, c_N);
        drive(1, 0, 1, 10, 1, 0, 0, c_N);
        drive(1, 0, 1, 11, 1, 0, 0, c_N);
        drive(1, 0, 1, 11, 1, 0, 0, c_N);
        drive(1, 10, 0, 0, 0, 0, 1, c_ST);
        drive(1, 10, 0, 0, 0, 1, 1, c_CL);
        for (int k = 1; k <= 32; k++) begin
            drive(1, 11, 1, 11, 1, (k == 10), 1, (k < 32) ? c_B : c_N);
        end
        for (int i = 0; i < 32; i++) drive(1, 5'(i), 0, 0, 0, 0, 1, c_N);

        // Reset during the 10th busy cycle aborts the walk
        drive(1, 0, 1, 12, 1, 0, 0, c_N);
        drive(1, 0, 1, 12, 1, 0, 0, c_N);
        drive(1, 12, 0, 0, 0, 0, 1, c_ST);
        drive(1, 0, 0, 0, 0, 1, 0, c_N);
        for (int k = 1; k <= 9; k++) drive(1, 0, 0, 0, 0, 0, 0, c_N);
        check_now("busy_mid_walk", {1'b0, 1'b0, busy}, c_B);
        arst_n = 1'b0;
        #1;
        check_now("reset_mid_walk", {prediction, pred_strong, busy}, c_N);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        drive(1, 12, 0, 0, 0, 0, 1, c_N);
        drive(1, 31, 0, 0, 0, 0, 1, c_N);
        drive(1, 7, 0, 0, 0, 0, 1, c_N);
        drive(0, 0, 0, 0, 0, 0, 0, c_N);
        drive(0, 0, 0, 0, 0, 0, 0, c_N);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised table of saturating branch-direction counters, indexed by the low PC bits supplied by fetch. It provides a registered taken/not-taken prediction plus confidence to the fetch stage, and accepts counter updates from execute once branches resolve. It also holds a flush state machine that re-initialises every entry on request without a global reset.

## Interface
Parameters:
- INDEX_BITS, 5, index width; table holds ENTRIES = 2^INDEX_BITS counters.
- CTR_BITS, 2, counter width (>= 1); prediction is the counter MSB.
- INIT_STATE, 1, value loaded into every counter on reset and on clear (must be < 2^CTR_BITS).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- arst_n  in  1  reset; asynchronous, active-low.
- en  in  1  pipeline enable; gates the read and update ports only.
- rd_addr  in  INDEX_BITS  index to predict for.
- wr_en  in  1  update request from execute.
- wr_addr  in  INDEX_BITS  index of the resolved branch.
- taken  in  1  resolved direction (1 = taken or unconditional jump).
- clear  in  1  single-cycle request to re-initialise the whole table.
- prediction  out  1  registered predicted direction.
- pred_strong  out  1  registered; 1 when the read counter is saturated (all ones or all zeros).
- busy  out  1  1 while the clear walk is in progress.

## Operation
- Storage: ENTRIES counters of CTR_BITS each.
- Read, when en=1 and busy=0: prediction <= ctr[rd_addr][CTR_BITS-1]; pred_strong <= (ctr[rd_addr] == all ones) or (ctr[rd_addr] == 0).
- Read while busy=1: prediction <= 0, pred_strong <= 0, regardless of en.
- Read with en=0 and busy=0: prediction and pred_strong hold.
- Update, when en=1, wr_en=1 and busy=0:
  - taken=1: ctr[wr_addr] increments, saturating at 2^CTR_BITS-1.
  - taken=0: ctr[wr_addr] decrements, saturating at 0.
  - No wrap-around, ever.
- Update with en=0 or busy=1 is dropped silently. It is not queued.
- Bypass: if an update is accepted in the same cycle as a read and rd_addr == wr_addr, prediction and pred_strong are computed from the post-update counter value.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear=1. clr_idx is set to 0 and busy goes to 1 on that edge.
  - In CLEAR, each cycle writes ctr[clr_idx] <= INIT_STATE and increments clr_idx.
  - When clr_idx == ENTRIES-1 is written, the FSM returns to IDLE and busy goes to 0 on that edge.
  - clear asserted while in CLEAR is ignored; the walk does not restart.
  - The FSM runs independently of en.
- clear and wr_en in the IDLE cycle where clear is sampled: the update is applied, and the walk later overwrites that entry.
- Reset (arst_n=0, immediate): every counter = INIT_STATE, prediction=0, pred_strong=0, busy=0, FSM=IDLE, clr_idx=0.
- Reset asserted mid-walk aborts the walk. The table is fully initialised by the reset itself.

## Timing
- Read latency is 1 cycle: rd_addr sampled at edge N appears on prediction/pred_strong after edge N.
- An update sampled at edge N is visible to a read with a different address sampled at edge N+1.
- An update to the same address at edge N is already visible through the bypass.
- Clear: clear sampled at edge N gives busy=1 after edge N. Entries are written at edges N+1 .. N+ENTRIES, and busy=0 after edge N+ENTRIES. The clear is therefore ENTRIES cycles of busy.
- The first accepted update or valid read follows at edge N+ENTRIES+1.
- All outputs are driven directly from flops; there are no combinational input-to-output paths.

## Test plan
- Reset then read: arst_n low, release, en=1, rd_addr=0..31 -> prediction=0 and pred_strong=0 for every index (INIT_STATE=1, CTR_BITS=2).
- Saturation up: three accepted updates taken=1 to index 7, then read 7 -> counter sequence 2,3,3; prediction=1, pred_strong=1. A fourth taken update leaves the counter at 3.
- Saturation down: from 3, three taken=0 updates to index 7 -> counter 2,1,0. Reads after each give prediction 1,0,0 and pred_strong 0,0,1. A further taken=0 update leaves the counter at 0.
- Bypass: counter[4]=1, same cycle wr_en=1, wr_addr=4, taken=1, rd_addr=4 -> prediction=1 one cycle later. The same stimulus with rd_addr=5 reads counter[5] unchanged.
- Clear walk:
  - Set several counters to 3, pulse clear for one cycle -> busy high for exactly 32 cycles, prediction=0 throughout.
  - Updates issued during busy are dropped.
  - A second clear pulse mid-walk does not extend busy.
  - Afterwards every entry reads prediction=0.
- Reset mid-walk and en gating:
  - Assert arst_n=0 during the 10th clear cycle -> busy=0 immediately, all entries at INIT_STATE.
  - With en=0, updates are ignored and prediction holds its last value.
